// File: rtl/nn_job_sequencer.sv
// Sequences one {x1..x6} vector at a time into an NN core and queues {y, cycles, timeout} results in a small FIFO.
// Accept edge -> 1-cycle start pulse; vec_ready drops while busy or FIFO full. NN_SEQ_TIMEOUT_EN adds a WAIT timeout.
module nn_job_sequencer #(
  parameter int RES_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic         clk_x70,
  input  logic         rst_n_x70,
  input  logic         vec_valid_x70,
  output logic         vec_ready_x70,
  input  logic [191:0] vec_data_x70,
  output logic [191:0] nn_x_x70,
  output logic         nn_start_x70,
  input  logic         nn_done_x70,
  input  logic [95:0]  nn_y_x70,
  output logic         res_valid_x70,
  input  logic         res_ready_x70,
  output logic [95:0]  res_data_x70,
  output logic [15:0]  res_cycles_x70,
  output logic         res_timeout_x70,
  output logic         busy_x70
);

  localparam int          AW     = $clog2(RES_DEPTH);
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);
`ifdef NN_SEQ_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, START, WAIT, STORE} state_t;

  typedef struct packed {
    logic [95:0] y;
    logic [15:0] cycles;
    logic        timeout;
  } res_t;

  state_t       r_state;
  logic         r_vec_ready;
  logic         r_nn_start;
  logic         r_busy;
  logic         r_done_d;
  logic [191:0] r_nn_x;
  logic [15:0]  r_cnt;
  res_t         r_cap;
  res_t         r_mem [RES_DEPTH];
  logic [AW:0]  r_wp;
  logic [AW:0]  r_rp;

  logic         w_empty;
  logic         w_push;
  logic         w_pop;
  logic         w_full_nxt;
  logic         w_done_rise;
  logic         w_to_hit;
  logic [AW:0]  w_wp_nxt;
  logic [AW:0]  w_rp_nxt;
  logic [15:0]  w_cnt_inc;
  res_t         w_head;

  assign w_empty     = (r_wp == r_rp);
  assign w_push      = (r_state == STORE);
  assign w_pop       = !w_empty && res_ready_x70;
  assign w_wp_nxt    = r_wp + {{AW{1'b0}}, w_push};
  assign w_rp_nxt    = r_rp + {{AW{1'b0}}, w_pop};
  // Ready for the next vector must account for a push/pop landing on this same edge.
  assign w_full_nxt  = (w_wp_nxt[AW] != w_rp_nxt[AW]) && (w_wp_nxt[AW-1:0] == w_rp_nxt[AW-1:0]);
  assign w_done_rise = nn_done_x70 && !r_done_d;
  assign w_cnt_inc   = (r_cnt == 16'hFFFF) ? 16'hFFFF : r_cnt + 16'd1;
  assign w_to_hit    = TO_EN && (w_cnt_inc == TO_LIM);
  assign w_head      = r_mem[r_rp[AW-1:0]];

  always_ff @(posedge clk_x70 or negedge rst_n_x70) begin
    if (!rst_n_x70) begin
      r_state     <= IDLE;
      r_vec_ready <= 1'b0;
      r_nn_start  <= 1'b0;
      r_busy      <= 1'b0;
      r_done_d    <= 1'b0;
      r_nn_x      <= '0;
      r_cnt       <= '0;
      r_cap       <= '0;
    end else begin
      r_done_d   <= nn_done_x70;
      r_nn_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (vec_valid_x70 && r_vec_ready) begin
            r_nn_x      <= vec_data_x70;
            r_nn_start  <= 1'b1;
            r_vec_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= START;
          end else begin
            r_vec_ready <= !w_full_nxt;
          end
        end
        START: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          // The cycle in which done is sampled high is part of the count.
          r_cnt <= w_cnt_inc;
          if (w_done_rise) begin
            r_cap   <= res_t'{y: nn_y_x70, cycles: w_cnt_inc, timeout: 1'b0};
            r_state <= STORE;
          end else if (w_to_hit) begin
            r_cap   <= res_t'{y: 96'd0, cycles: TO_LIM, timeout: 1'b1};
            r_state <= STORE;
          end
        end
        STORE: begin
          r_busy      <= 1'b0;
          r_vec_ready <= !w_full_nxt;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_x70 or negedge rst_n_x70) begin
    if (!rst_n_x70) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      r_wp <= w_wp_nxt;
      r_rp <= w_rp_nxt;
    end
  end

  always_ff @(posedge clk_x70) begin
    if (w_push) begin
      r_mem[r_wp[AW-1:0]] <= r_cap;
    end
  end

  assign vec_ready_x70   = r_vec_ready;
  assign nn_x_x70        = r_nn_x;
  assign nn_start_x70    = r_nn_start;
  assign busy_x70        = r_busy;
  assign res_valid_x70   = !w_empty;
  assign res_data_x70    = w_empty ? 96'd0 : w_head.y;
  assign res_cycles_x70  = w_empty ? 16'd0 : w_head.cycles;
  assign res_timeout_x70 = !w_empty && w_head.timeout && TO_EN;

endmodule

// File: tb/tb_nn_job_sequencer.sv
// Randomized and directed bench for nn_job_sequencer; a behavioural NN core model predicts every queued result.
module tb_nn_job_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         vec_valid;
  logic         vec_ready;
  logic [191:0] vec_data;
  logic [191:0] nn_x;
  logic         nn_start;
  logic         nn_done;
  logic [95:0]  nn_y;
  logic         res_valid;
  logic         res_ready;
  logic [95:0]  res_data;
  logic [15:0]  res_cycles;
  logic         res_timeout;
  logic         busy;

  always #5 clk = ~clk;

  nn_job_sequencer #(.RES_DEPTH(4), .TIMEOUT_CYC(16)) dut (
    .clk_x70(clk), .rst_n_x70(rst_n),
    .vec_valid_x70(vec_valid), .vec_ready_x70(vec_ready), .vec_data_x70(vec_data),
    .nn_x_x70(nn_x), .nn_start_x70(nn_start), .nn_done_x70(nn_done), .nn_y_x70(nn_y),
    .res_valid_x70(res_valid), .res_ready_x70(res_ready), .res_data_x70(res_data),
    .res_cycles_x70(res_cycles), .res_timeout_x70(res_timeout), .busy_x70(busy)
  );

  typedef struct {
    logic [95:0] y;
    int          cyc;
  } job_t;

  int           n_checks = 0;
  int           n_fail   = 0;
  job_t         plan_q[$];
  job_t         exp_q[$];
  logic [191:0] seen_x_q[$];
  logic [191:0] sent_q[$];
  int           n_starts = 0;
  bit           net_auto = 1'b0;
  logic         a_done = 1'b0;
  logic [95:0]  a_y = '0;
  logic         m_done = 1'b0;
  logic [95:0]  m_y = '0;
  logic [191:0] b2b_v[5];
  logic [95:0]  b2b_y[5];
  int           b2b_acc;
  int           rnd_got;

  assign nn_done = a_done | m_done;
  assign nn_y    = a_done ? a_y : m_y;

  // Network model: done rises 'cyc' cycles after the start cycle, so the expected count is exactly cyc.
  initial begin : net_model
    forever begin
      @(negedge clk);
      if (nn_start === 1'b1) begin
        n_starts++;
        seen_x_q.push_back(nn_x);
        if (net_auto) begin
          job_t j;
          if (plan_q.size() > 0) j = plan_q.pop_front();
          else begin
            j.cyc = $urandom_range(12, 1);
            j.y   = {$urandom, $urandom, $urandom};
          end
          exp_q.push_back(j);
          repeat (j.cyc) @(posedge clk);
          #1 a_done = 1'b1; a_y = j.y;
          @(posedge clk);
          #1 a_done = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  task automatic apply_reset();
    rst_n = 1'b0; vec_valid = 1'b0; res_ready = 1'b0; m_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_vec(input logic [191:0] v, input int budget, output bit ok);
    ok = 1'b0;
    @(posedge clk); #1;
    vec_valid = 1'b1; vec_data = v;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (vec_ready === 1'b1) begin
        @(posedge clk); #1;
        vec_valid = 1'b0;
        ok = 1'b1;
        return;
      end
    end
    vec_valid = 1'b0;
  endtask

  task automatic wait_res(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic pop_one();
    @(posedge clk); #1 res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vec_valid = 1'b0; vec_data = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({vec_ready, nn_start, busy, res_valid, res_timeout} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000", {vec_ready, nn_start, busy, res_valid, res_timeout});
    end
    n_checks++;
    if ({nn_x, res_data, res_cycles} !== '0) begin
      n_fail++; $display("FAIL reset_data: got nn_x=%h res=%h cyc=%h expected 0", nn_x, res_data, res_cycles);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (vec_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready_before_edge: got %b expected 0", vec_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({vec_ready, busy} !== 2'b10) begin
      n_fail++; $display("FAIL reset_ready_after_edge: got ready,busy=%b expected 10", {vec_ready, busy});
    end
  endtask

  task automatic test_single();
    logic [191:0] v;
    logic [95:0]  y;
    bit           ok;
    int           s0;
    v = '0; v[127:96] = 32'h3A83126F;
    y = {32'h3F800000, 32'h00000000, 32'hBF800000};
    net_auto = 1'b1; res_ready = 1'b0;
    plan_q.push_back(job_t'{y: y, cyc: 7});
    s0 = n_starts;
    send_vec(v, 50, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_accept: vector not accepted within budget"); end
    wait_res(100, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_result: no result within budget"); end
    n_checks++;
    if (n_starts - s0 !== 1) begin n_fail++; $display("FAIL single_starts: got %0d expected 1", n_starts - s0); end
    n_checks++;
    if (nn_x !== v) begin n_fail++; $display("FAIL single_nn_x: got %h expected %h", nn_x, v); end
    n_checks++;
    if ({res_data, res_cycles, res_timeout} !== {y, 16'd7, 1'b0}) begin
      n_fail++; $display("FAIL single_entry: got %h/%0d/%b expected %h/7/0", res_data, res_cycles, res_timeout, y);
    end
    @(negedge clk);
    n_checks++;
    if ({busy, vec_ready} !== 2'b01) begin n_fail++; $display("FAIL single_idle: got busy,ready=%b expected 01", {busy, vec_ready}); end
    pop_one();
    @(negedge clk);
    n_checks++;
    if ({res_valid, res_data, res_cycles, res_timeout} !== '0) begin
      n_fail++; $display("FAIL single_empty_zero: got v=%b %h/%0d/%b expected all 0", res_valid, res_data, res_cycles, res_timeout);
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int s0;
    net_auto = 1'b1; res_ready = 1'b0; b2b_acc = 0;
    exp_q.delete(); seen_x_q.delete();
    for (int i = 0; i < 5; i++) begin
      b2b_v[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      b2b_y[i] = {$urandom, $urandom, $urandom};
      plan_q.push_back(job_t'{y: b2b_y[i], cyc: 3});
    end
    s0 = n_starts;
    fork
      begin
        bit pok;
        for (int i = 0; i < 5; i++) begin
          send_vec(b2b_v[i], 400, pok);
          if (pok) b2b_acc++;
        end
      end
    join_none
    repeat (80) @(negedge clk);
    n_checks++;
    if (n_starts - s0 !== 4) begin n_fail++; $display("FAIL b2b_starts_full: got %0d expected 4", n_starts - s0); end
    n_checks++;
    if ({vec_ready, res_valid} !== 2'b01) begin n_fail++; $display("FAIL b2b_ready_low: got ready,valid=%b expected 01", {vec_ready, res_valid}); end
    n_checks++;
    if (b2b_acc !== 4) begin n_fail++; $display("FAIL b2b_accepted: got %0d expected 4", b2b_acc); end
    n_checks++;
    if (res_data !== b2b_y[0]) begin n_fail++; $display("FAIL b2b_head0: got %h expected %h", res_data, b2b_y[0]); end
    pop_one();
    for (int k = 0; k < 100 && b2b_acc < 5; k++) @(negedge clk);
    repeat (20) @(negedge clk);
    n_checks++;
    if (n_starts - s0 !== 5 || b2b_acc !== 5) begin
      n_fail++; $display("FAIL b2b_fifth: got starts=%0d acc=%0d expected 5/5", n_starts - s0, b2b_acc);
    end
    for (int i = 1; i < 5; i++) begin
      bit ok;
      wait_res(20, ok);
      n_checks++;
      if (!ok || res_data !== b2b_y[i] || res_cycles !== 16'd3) begin
        n_fail++; $display("FAIL b2b_order[%0d]: got %h/%0d expected %h/3", i, res_data, res_cycles, b2b_y[i]);
      end
      pop_one();
    end
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got valid=%b expected 0", res_valid); end
    n_checks++;
    if (seen_x_q.size() != 5) begin
      n_fail++; $display("FAIL b2b_nn_x_count: got %0d expected 5", seen_x_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (seen_x_q[i] !== b2b_v[i]) begin n_fail++; $display("FAIL b2b_nn_x[%0d]: got %h expected %h", i, seen_x_q[i], b2b_v[i]); end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_done_held();
    logic [95:0] y;
    bit          ok;
    int          s0;
    net_auto = 1'b0; res_ready = 1'b0;
    y = {$urandom, $urandom, $urandom};
    m_y = y; m_done = 1'b1;
    s0 = n_starts;
    send_vec({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 50, ok);
    @(negedge clk);
    n_checks++;
    if (!ok || nn_start !== 1'b1) begin n_fail++; $display("FAIL held_start: got ok=%b start=%b expected 1/1", ok, nn_start); end
    @(posedge clk); #1;
    @(posedge clk); #1 m_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, res_valid} !== 2'b10) begin n_fail++; $display("FAIL held_ignored: got busy,valid=%b expected 10", {busy, res_valid}); end
    m_done = 1'b1;
    @(posedge clk); #1 m_done = 1'b0;
    wait_res(10, ok);
    n_checks++;
    if (!ok || {res_data, res_cycles, res_timeout} !== {y, 16'd5, 1'b0}) begin
      n_fail++; $display("FAIL held_entry: got %h/%0d/%b expected %h/5/0", res_data, res_cycles, res_timeout, y);
    end
    pop_one();
    repeat (10) @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b0 || n_starts - s0 !== 1) begin
      n_fail++; $display("FAIL held_single: got valid=%b starts=%0d expected 0/1", res_valid, n_starts - s0);
    end
  endtask

  task automatic test_reset_mid();
    logic [191:0] vb;
    bit           ok;
    net_auto = 1'b1; res_ready = 1'b0;
    plan_q.push_back(job_t'{y: {$urandom, $urandom, $urandom}, cyc: 2});
    send_vec({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 50, ok);
    wait_res(50, ok);
    net_auto = 1'b0; m_done = 1'b0;
    vb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom} | 192'd1;
    send_vec(vb, 50, ok);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, res_valid} !== 2'b11 || nn_x !== vb) begin
      n_fail++; $display("FAIL midrst_pre: got busy,valid=%b nn_x=%h expected 11/%h", {busy, res_valid}, nn_x, vb);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({vec_ready, nn_start, busy, res_valid, res_timeout} !== 5'b0 || {nn_x, res_data, res_cycles} !== '0) begin
      n_fail++; $display("FAIL midrst_outputs: got flags=%b nn_x=%h res=%h cyc=%h expected 0",
                         {vec_ready, nn_start, busy, res_valid, res_timeout}, nn_x, res_data, res_cycles);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (vec_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b expected 1", vec_ready); end
    repeat (10) @(negedge clk);
    n_checks++;
    if ({res_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL midrst_no_push: got valid,busy=%b expected 00", {res_valid, busy}); end
    exp_q.delete();
  endtask

  task automatic test_timeout();
    bit ok;
    net_auto = 1'b0; m_done = 1'b0; res_ready = 1'b0;
    m_y = {$urandom, $urandom, $urandom} | 96'd1;
    send_vec({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 50, ok);
`ifdef NN_SEQ_TIMEOUT_EN
    wait_res(60, ok);
    n_checks++;
    if (!ok || {res_data, res_cycles, res_timeout} !== {96'd0, 16'd16, 1'b1}) begin
      n_fail++; $display("FAIL timeout_entry: got %h/%0d/%b expected 0/16/1", res_data, res_cycles, res_timeout);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, vec_ready} !== 2'b01) begin n_fail++; $display("FAIL timeout_idle: got busy,ready=%b expected 01", {busy, vec_ready}); end
    pop_one();
`else
    repeat (60) @(negedge clk);
    n_checks++;
    if ({busy, res_valid} !== 2'b10) begin n_fail++; $display("FAIL no_timeout_wait: got busy,valid=%b expected 10", {busy, res_valid}); end
    apply_reset();
`endif
  endtask

  task automatic test_same_cycle();
    logic [95:0] ya, yb;
    bit          ok;
    ya = {$urandom, $urandom, $urandom};
    yb = ~ya;
    net_auto = 1'b1; res_ready = 1'b0;
    plan_q.push_back(job_t'{y: ya, cyc: 2});
    send_vec({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 50, ok);
    wait_res(50, ok);
    net_auto = 1'b0; m_done = 1'b0;
    send_vec({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 50, ok);
    repeat (4) @(posedge clk);
    #1 m_done = 1'b1; m_y = yb;
    @(posedge clk); #1 m_done = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (res_data !== ya) begin n_fail++; $display("FAIL same_head_before: got %h expected %h", res_data, ya); end
    @(posedge clk); #1 res_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({res_valid, res_data, res_cycles} !== {1'b1, yb, 16'd4}) begin
      n_fail++; $display("FAIL same_head_after: got v=%b %h/%0d expected 1 %h/4", res_valid, res_data, res_cycles, yb);
    end
    pop_one();
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b0) begin n_fail++; $display("FAIL same_occupancy: got valid=%b expected 0", res_valid); end
    exp_q.delete();
  endtask

  task automatic test_random();
    localparam int N = 30;
    exp_q.delete(); seen_x_q.delete(); sent_q.delete(); plan_q.delete();
    net_auto = 1'b1; res_ready = 1'b0; rnd_got = 0;
    fork
      begin
        bit pok;
        logic [191:0] v;
        for (int i = 0; i < N; i++) begin
          repeat ($urandom_range(3, 0)) begin
            @(posedge clk); #1 vec_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
          end
          v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
          send_vec(v, 2000, pok);
          if (!pok) break;
          sent_q.push_back(v);
        end
      end
      begin
        job_t e;
        for (int k = 0; k < 6000 && rnd_got < N; k++) begin
          @(posedge clk); #1 res_ready = 1'($urandom_range(1, 0));
          @(negedge clk);
          if (res_valid && res_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++; $display("FAIL rnd_unexpected: got %h/%0d with no job outstanding", res_data, res_cycles);
            end else begin
              e = exp_q.pop_front();
              if ({res_data, res_cycles, res_timeout} !== {e.y, 16'(e.cyc), 1'b0}) begin
                n_fail++; $display("FAIL rnd_entry[%0d]: got %h/%0d/%b expected %h/%0d/0", rnd_got, res_data, res_cycles, res_timeout, e.y, e.cyc);
              end
            end
            rnd_got++;
          end else if (!res_valid) begin
            n_checks++;
            if ({res_data, res_cycles, res_timeout} !== '0) begin
              n_fail++; $display("FAIL rnd_empty_zero: got %h/%0d/%b expected 0", res_data, res_cycles, res_timeout);
            end
          end
          if (sent_q.size() > 0) begin
            n_checks++;
            if (nn_x !== sent_q[$]) begin n_fail++; $display("FAIL rnd_nn_x_hold: got %h expected %h", nn_x, sent_q[$]); end
          end
        end
      end
    join
    res_ready = 1'b0;
    n_checks++;
    if (rnd_got !== N || sent_q.size() != N) begin
      n_fail++; $display("FAIL rnd_count: got results=%0d sent=%0d expected %0d", rnd_got, sent_q.size(), N);
    end
    n_checks++;
    if (seen_x_q != sent_q) begin n_fail++; $display("FAIL rnd_nn_x_seq: got %0d starts, sequence differs from %0d sent", seen_x_q.size(), sent_q.size()); end
  endtask

  initial begin : main
    test_reset();
    test_single();
    test_back_to_back();
    test_done_held();
    test_reset_mid();
    test_timeout();
    test_same_cycle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
